// File: rtl/ysyx_22040237_lsu_pkg.sv
// ysyx_22040237_lsu_pkg: shared LSU defines (XLEN, ls_info bit indices, FSM state encodings, access size)
package ysyx_22040237_lsu_pkg;
  localparam int XLEN = 64;
  localparam int LS_LOAD = 0;
  localparam int LS_STORE = 1;
  localparam int LS_USIGN = 2;
  localparam int LS_BYTE = 3;
  localparam int LS_DB = 4;
  localparam int LS_WORD = 5;
  localparam int LS_DW = 6;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [1:0] S_WB = 2'd3;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
endpackage

// File: rtl/ysyx_22040237_lsu_align.sv
// ysyx_22040237_lsu_align: size decode, misalign check, store lane replication/strobes, load extract+extend (ls_info/off/sdata/rdata in; is_ls/misalign/wdata/wstrb/ldata out)
module ysyx_22040237_lsu_align
  import ysyx_22040237_lsu_pkg::*;
(
  input  logic [6:0]      ls_info,
  input  logic [2:0]      off,
  input  logic [XLEN-1:0] sdata,
  input  logic [XLEN-1:0] rdata,
  output logic            is_ls,
  output logic            misalign,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wstrb,
  output logic [XLEN-1:0] ldata
);
  size_e sz;
  logic sx;
  logic [XLEN-1:0] sh;
  always_comb begin
    sz = ls_info[LS_DW] ? SZ_D : ls_info[LS_WORD] ? SZ_W : ls_info[LS_DB] ? SZ_H : ls_info[LS_BYTE] ? SZ_B : SZ_B;
    is_ls = ls_info[LS_LOAD] | ls_info[LS_STORE];
    misalign = sz == SZ_D ? off != 3'd0 : sz == SZ_W ? off[1:0] != 2'd0 : sz == SZ_H && off[0];
    wdata = sz == SZ_D ? sdata : sz == SZ_W ? {2{sdata[31:0]}} : sz == SZ_H ? {4{sdata[15:0]}} : {8{sdata[7:0]}};
    wstrb = !ls_info[LS_STORE] ? 8'h00 : sz == SZ_D ? 8'hFF : (sz == SZ_W ? 8'h0F : sz == SZ_H ? 8'h03 : 8'h01) << off;
    sh = rdata >> {off, 3'b000};
    sx = ~ls_info[LS_USIGN];
    ldata = sz == SZ_D ? sh : sz == SZ_W ? {{32{sx & sh[31]}}, sh[31:0]} :
            sz == SZ_H ? {{48{sx & sh[15]}}, sh[15:0]} : {{56{sx & sh[7]}}, sh[7:0]};
  end
endmodule

// File: rtl/ysyx_22040237_lsu.sv
// ysyx_22040237_lsu: IDLE/REQ/RESP/WB load-store FSM; ex_* in, mem_* req/gnt/rvalid bus, wb_* result out with misalign/bus-error flags
module ysyx_22040237_lsu
  import ysyx_22040237_lsu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  output logic            ex_ready_o,
  input  logic            rd_wr_en_i,
  input  logic [4:0]      rd_idx_i,
  input  logic [XLEN-1:0] alu_res_i,
  input  logic [6:0]      ls_info_bus_i,
  input  logic [XLEN-1:0] rs2_store_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [7:0]      mem_wstrb_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic            wb_rd_wr_en_o,
  output logic [4:0]      wb_rd_idx_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            lsu_misalign_o,
  output logic            lsu_bus_err_o
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [1:0] state;
  logic [CW-1:0] cnt;
  logic [XLEN-1:0] addr_q, wd_q, wb_data_q, wdata, ldata;
  logic [6:0] info_q, info_s;
  logic [7:0] ws_q, wstrb;
  logic [4:0] rd_idx_q;
  logic [2:0] off_s;
  logic rd_we_q, wb_we_q, mis_q, berr_q, is_ls, misalign, tmo;
  assign info_s = state == S_IDLE ? ls_info_bus_i : info_q;
  assign off_s = state == S_IDLE ? alu_res_i[2:0] : addr_q[2:0];
  assign tmo = cnt == CW'(MEM_TIMEOUT - 1);
  ysyx_22040237_lsu_align u_align (
    .ls_info  (info_s),
    .off      (off_s),
    .sdata    (rs2_store_i),
    .rdata    (mem_rdata_i),
    .is_ls    (is_ls),
    .misalign (misalign),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .ldata    (ldata)
  );
  assign ex_ready_o = state == S_IDLE;
  assign mem_req_o = state == S_REQ;
  assign mem_we_o = info_q[LS_STORE];
  assign mem_addr_o = {addr_q[XLEN-1:3], 3'b000};
  assign mem_wdata_o = wd_q;
  assign mem_wstrb_o = ws_q;
  assign wb_valid_o = state == S_WB;
  assign wb_rd_wr_en_o = wb_we_q;
  assign wb_rd_idx_o = rd_idx_q;
  assign wb_data_o = wb_data_q;
  assign lsu_misalign_o = mis_q;
  assign lsu_bus_err_o = berr_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt <= '0;
      addr_q <= '0;
      info_q <= '0;
      rd_idx_q <= '0;
      rd_we_q <= 1'b0;
      wd_q <= '0;
      ws_q <= '0;
      wb_data_q <= '0;
      wb_we_q <= 1'b0;
      mis_q <= 1'b0;
      berr_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (ex_valid_i) begin
          addr_q <= alu_res_i;
          info_q <= ls_info_bus_i;
          rd_idx_q <= rd_idx_i;
          rd_we_q <= rd_wr_en_i;
          wd_q <= wdata;
          ws_q <= wstrb;
          cnt <= '0;
          wb_data_q <= alu_res_i;
          wb_we_q <= rd_wr_en_i & ~is_ls;
          mis_q <= is_ls & misalign;
          berr_q <= 1'b0;
          state <= is_ls && !misalign ? S_REQ : S_WB;
        end
        S_REQ: begin
          cnt <= cnt + CW'(1);
          if (mem_gnt_i) state <= info_q[LS_STORE] ? S_WB : S_RESP;
          else if (tmo) begin
            state <= S_WB;
            berr_q <= 1'b1;
          end
        end
        S_RESP: begin
          cnt <= cnt + CW'(1);
          if (mem_rvalid_i) begin
            state <= S_WB;
            wb_data_q <= ldata;
            wb_we_q <= rd_we_q;
          end else if (tmo) begin
            state <= S_WB;
            berr_q <= 1'b1;
          end
        end
        default: if (wb_ready_i) state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22040237_lsu.sv
// tb_ysyx_22040237_lsu: directed scoreboard bench for the LSU
module tb_ysyx_22040237_lsu;
  logic clk = 1'b0, rst = 1'b1;
  logic ex_valid_i = 1'b0, rd_wr_en_i = 1'b0, ex_ready_o;
  logic [4:0] rd_idx_i = '0;
  logic [63:0] alu_res_i = '0, rs2_store_i = '0, mem_rdata_i = '0;
  logic [6:0] ls_info_bus_i = '0;
  logic mem_req_o, mem_we_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [63:0] mem_addr_o, mem_wdata_o, wb_data_o;
  logic [7:0] mem_wstrb_o;
  logic wb_valid_o, wb_ready_i = 1'b1, wb_rd_wr_en_o, lsu_misalign_o, lsu_bus_err_o;
  logic [4:0] wb_rd_idx_o;
  always #5 clk = ~clk;
  ysyx_22040237_lsu #(.MEM_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
    .rd_wr_en_i(rd_wr_en_i), .rd_idx_i(rd_idx_i), .alu_res_i(alu_res_i),
    .ls_info_bus_i(ls_info_bus_i), .rs2_store_i(rs2_store_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_rd_wr_en_o(wb_rd_wr_en_o),
    .wb_rd_idx_o(wb_rd_idx_o), .wb_data_o(wb_data_o),
    .lsu_misalign_o(lsu_misalign_o), .lsu_bus_err_o(lsu_bus_err_o)
  );
  typedef struct {logic [63:0] d; logic we; logic [4:0] idx; logic mis; logic berr; logic cd;} wb_t;
  typedef struct {logic [63:0] a; logic we; logic [63:0] wd; logic [7:0] ws;} mem_t;
  wb_t wq[$];
  mem_t mq[$];
  wb_t wx;
  mem_t mx;
  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst && wb_valid_o && wb_ready_i) begin
      if (wq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL wb_unexpected: got result data %h, required no result", wb_data_o);
      end else begin
        wx = wq.pop_front();
        chk("wb_idx", 64'(wb_rd_idx_o), 64'(wx.idx));
        chk("wb_we", 64'(wb_rd_wr_en_o), 64'(wx.we));
        chk("wb_misalign", 64'(lsu_misalign_o), 64'(wx.mis));
        chk("wb_bus_err", 64'(lsu_bus_err_o), 64'(wx.berr));
        if (wx.cd) chk("wb_data", wb_data_o, wx.d);
      end
    end
    if (!rst && mem_req_o && mem_gnt_i) begin
      if (mq.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL mem_unexpected: got request at %h, required none", mem_addr_o);
      end else begin
        mx = mq.pop_front();
        chk("mem_addr", mem_addr_o, mx.a);
        chk("mem_we", 64'(mem_we_o), 64'(mx.we));
        chk("mem_wdata", mem_wdata_o, mx.wd);
        chk("mem_wstrb", 64'(mem_wstrb_o), 64'(mx.ws));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic exp_wb(input logic [63:0] d, input logic we, input logic [4:0] idx, input logic mis, input logic berr, input logic cd);
    wb_t w;
    w = '{d, we, idx, mis, berr, cd};
    wq.push_back(w);
  endtask
  task automatic exp_mem(input logic [63:0] a, input logic we, input logic [63:0] wd, input logic [7:0] ws);
    mem_t m;
    m = '{a, we, wd, ws};
    mq.push_back(m);
  endtask
  task automatic issue(input logic [6:0] info, input logic [63:0] a, input logic [63:0] rs2, input logic [4:0] rd);
    int k = 0;
    while (!ex_ready_o && k < 50) begin
      tick();
      k++;
    end
    chk("issue_ready", 64'(ex_ready_o), 64'd1);
    ex_valid_i = 1'b1;
    ls_info_bus_i = info;
    alu_res_i = a;
    rs2_store_i = rs2;
    rd_idx_i = rd;
    rd_wr_en_i = 1'b1;
    tick();
    ex_valid_i = 1'b0;
    ls_info_bus_i = '0;
  endtask
  task automatic serve(input int gd, input bit ld, input logic [63:0] rdata);
    logic [63:0] sa, sw;
    logic [7:0] ss;
    sa = mem_addr_o;
    sw = mem_wdata_o;
    ss = mem_wstrb_o;
    chk("req_up", 64'(mem_req_o), 64'd1);
    for (int i = 0; i < gd; i++) begin
      tick();
      chk("req_held", 64'(mem_req_o), 64'd1);
      chk("addr_held", mem_addr_o, sa);
      chk("wdata_held", mem_wdata_o, sw);
      chk("wstrb_held", 64'(mem_wstrb_o), 64'(ss));
    end
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("req_drop", 64'(mem_req_o), 64'd0);
    if (ld) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i = rdata;
      tick();
      mem_rvalid_i = 1'b0;
    end
  endtask
  task automatic do_load(input logic [6:0] info, input logic [63:0] a, input logic [63:0] rdata, input logic [63:0] exp, input logic [4:0] rd);
    exp_mem({a[63:3], 3'b000}, 1'b0, 64'h0, 8'h00);
    exp_wb(exp, 1'b1, rd, 1'b0, 1'b0, 1'b1);
    issue(info, a, 64'h0, rd);
    serve(0, 1'b1, rdata);
    chk("ld_latency", 64'(wb_valid_o), 64'd1);
  endtask
  task automatic do_store(input logic [6:0] info, input logic [63:0] a, input logic [63:0] rs2, input int gd,
                          input logic [63:0] wd, input logic [7:0] ws, input logic [4:0] rd);
    exp_mem({a[63:3], 3'b000}, 1'b1, wd, ws);
    exp_wb(64'h0, 1'b0, rd, 1'b0, 1'b0, 1'b0);
    issue(info, a, rs2, rd);
    serve(gd, 1'b0, 64'h0);
    chk("st_latency", 64'(wb_valid_o), 64'd1);
  endtask
  task automatic do_mis(input logic [6:0] info, input logic [63:0] a, input logic [4:0] rd);
    exp_wb(64'h0, 1'b0, rd, 1'b1, 1'b0, 1'b0);
    issue(info, a, 64'h0, rd);
    chk("mis_latency", 64'(wb_valid_o), 64'd1);
    chk("mis_noreq", 64'(mem_req_o), 64'd0);
  endtask
  task automatic check_reset();
    chk("rst_ready", 64'(ex_ready_o), 64'd1);
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_addr", mem_addr_o, 64'h0);
    chk("rst_wdata", mem_wdata_o, 64'h0);
    chk("rst_wb_data", wb_data_o, 64'h0);
    chk("rst_misc", 64'({mem_we_o, mem_wstrb_o, wb_rd_wr_en_o, wb_rd_idx_o, lsu_misalign_o, lsu_bus_err_o}), 64'h0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1);
  end
  initial begin
    int k;
    repeat (3) tick();
    check_reset();
    rst = 1'b0;
    tick();
    exp_wb(64'h1234, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1);
    issue(7'h00, 64'h1234, 64'h0, 5'd5);
    chk("pt_latency", 64'(wb_valid_o), 64'd1);
    chk("pt_noreq", 64'(mem_req_o), 64'd0);
    do_load(7'h09, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80, 5'd7);
    do_load(7'h0D, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080, 5'd8);
    do_load(7'h11, 64'h8000_0002, 64'h0000_0000_8765_0000, 64'hFFFF_FFFF_FFFF_8765, 5'd10);
    do_load(7'h21, 64'h8000_0004, 64'h9ABC_DEF0_0000_0000, 64'hFFFF_FFFF_9ABC_DEF0, 5'd11);
    do_load(7'h25, 64'h8000_0004, 64'h9ABC_DEF0_0000_0000, 64'h0000_0000_9ABC_DEF0, 5'd12);
    do_load(7'h41, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 5'd13);
    do_load(7'h01, 64'h8000_0007, 64'hF000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFF0, 5'd14);
    do_store(7'h12, 64'h8000_0006, 64'h1111_2222_3333_ABCD, 3, 64'hABCD_ABCD_ABCD_ABCD, 8'hC0, 5'd3);
    do_store(7'h22, 64'h8000_0004, 64'h1122_3344_5566_7788, 0, 64'h5566_7788_5566_7788, 8'hF0, 5'd15);
    do_store(7'h0A, 64'h8000_0005, 64'h0000_0000_0000_00EE, 1, 64'hEEEE_EEEE_EEEE_EEEE, 8'h20, 5'd16);
    do_store(7'h42, 64'h8000_0008, 64'hCAFE_BABE_DEAD_BEEF, 0, 64'hCAFE_BABE_DEAD_BEEF, 8'hFF, 5'd17);
    do_store(7'h13, 64'h8000_0002, 64'h0000_0000_0000_5A5A, 0, 64'h5A5A_5A5A_5A5A_5A5A, 8'h0C, 5'd18);
    do_mis(7'h21, 64'h8000_0002, 5'd9);
    do_mis(7'h12, 64'h8000_0001, 5'd19);
    do_mis(7'h61, 64'h8000_0004, 5'd20);
    exp_wb(64'h0, 1'b0, 5'd4, 1'b0, 1'b1, 1'b0);
    issue(7'h21, 64'h0000_0100, 64'h0, 5'd4);
    k = 0;
    while (mem_req_o && k < 20) begin
      k++;
      tick();
    end
    chk("tmo_req_cycles", 64'(k), 64'd8);
    chk("tmo_wb", 64'(wb_valid_o), 64'd1);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = '1;
    tick();
    tick();
    mem_rvalid_i = 1'b0;
    chk("tmo_late_idle", 64'({ex_ready_o, wb_valid_o, mem_req_o}), 64'b100);
    wb_ready_i = 1'b0;
    exp_wb(64'hDEAD_BEEF, 1'b1, 5'd2, 1'b0, 1'b0, 1'b1);
    issue(7'h00, 64'hDEAD_BEEF, 64'h0, 5'd2);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 64'(wb_valid_o), 64'd1);
      chk("bp_data", wb_data_o, 64'hDEAD_BEEF);
      chk("bp_not_ready", 64'(ex_ready_o), 64'd0);
      tick();
    end
    wb_ready_i = 1'b1;
    tick();
    chk("bp_release", 64'({ex_ready_o, wb_valid_o}), 64'b10);
    exp_mem(64'h8000_0020, 1'b0, 64'h0, 8'h00);
    issue(7'h21, 64'h8000_0020, 64'h0, 5'd6);
    mem_gnt_i = 1'b1;
    tick();
    mem_gnt_i = 1'b0;
    chk("rr_in_resp", 64'({ex_ready_o, mem_req_o, wb_valid_o}), 64'b000);
    rst = 1'b1;
    tick();
    check_reset();
    rst = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'h5555_5555_5555_5555;
    tick();
    mem_rvalid_i = 1'b0;
    tick();
    chk("rr_no_wb", 64'({ex_ready_o, wb_valid_o}), 64'b10);
    exp_wb(64'h0000_0000_0000_0055, 1'b1, 5'd21, 1'b0, 1'b0, 1'b1);
    do_load(7'h0D, 64'h8000_0000, 64'h0000_0000_0000_0055, 64'h0000_0000_0000_0055, 5'd21);
    void'(wq.pop_back());
    tick();
    tick();
    chk("wq_empty", 64'(wq.size()), 64'd0);
    chk("mq_empty", 64'(mq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_22040237_lsu.md
# ysyx_22040237_lsu

Load/store unit sitting between the execute stage and write-back in the ysyx_22040237 RV64 core. Consumes the execute stage's load/store info bus, effective address and store data. Performs one 64-bit memory transaction over a req/gnt/rvalid data bus, with lane alignment, byte strobes and load sign/zero extension, then hands a register write-back result downstream. Non-memory instructions pass through with their ALU result after one registered cycle.

## Interface
- MEM_TIMEOUT, 256: cycles spent in REQ+RESP before the transaction is abandoned with a bus error.
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- ex_valid_i  in  1  execute result valid
- ex_ready_o  out  1  LSU can accept (high only in IDLE)
- rd_wr_en_i  in  1  destination write enable
- rd_idx_i  in  5  destination register
- alu_res_i  in  64  ALU result / effective address
- ls_info_bus_i  in  7  {dw, word, half(db), byte, usign, store, load}, bit 0 = load
- rs2_store_i  in  64  store data
- mem_req_o  out  1  bus request
- mem_we_o  out  1  1 = store
- mem_addr_o  out  64  address, bits [2:0] forced to 0
- mem_wdata_o  out  64  lane-replicated store data
- mem_wstrb_o  out  8  byte strobes; 0 for loads
- mem_gnt_i  in  1  request accepted
- mem_rvalid_i  in  1  load data valid
- mem_rdata_i  in  64  load data
- wb_valid_o  out  1  write-back result valid
- wb_ready_i  in  1  write-back accepts
- wb_rd_wr_en_o  out  1  write enable to regfile
- wb_rd_idx_o  out  5  destination register
- wb_data_o  out  64  result
- lsu_misalign_o  out  1  result is a misaligned-access fault (qualified by wb_valid_o)
- lsu_bus_err_o  out  1  result is a bus timeout (qualified by wb_valid_o)

## Operation
- States: IDLE, REQ, RESP, WB.
- IDLE: on ex_valid_i, latch all inputs.
  - No load/store bit set: go to WB, wb_data = alu_res.
  - Load or store, aligned: go to REQ.
  - Misaligned: go to WB with lsu_misalign_o=1 and wb_rd_wr_en_o=0. Misaligned means half with addr[0]≠0, word with addr[1:0]≠0, dw with addr[2:0]≠0.
- Size priority when more than one size bit is set: dw > word > half > byte. No size bit set: byte. Store beats load if both are set.
- REQ: mem_req_o held high with stable addr/we/wdata/wstrb until mem_gnt_i.
  - Store granted: go to WB, wb_rd_wr_en_o=0.
  - Load granted: go to RESP.
- RESP: on mem_rvalid_i, go to WB with data = extend(mem_rdata_i >> 8·addr[2:0]).
  - Sign-extend from bit 7/15/31 unless usign is set, then zero-extend.
  - dw is unchanged.
- Store lanes and strobes:
  - byte: {8{d[7:0]}}, wstrb = 0x01<<off
  - half: {4{d[15:0]}}, wstrb = 0x03<<off
  - word: {2{d[31:0]}}, wstrb = 0x0F<<off
  - dw: d, wstrb = 0xFF
- Timeout counter: cleared on leaving IDLE, incremented each cycle in REQ/RESP. When it reaches MEM_TIMEOUT: drop mem_req_o, go to WB with lsu_bus_err_o=1 and wb_rd_wr_en_o=0.
- WB: outputs held stable until wb_ready_i, then go to IDLE.
- mem_rvalid_i and mem_gnt_i are ignored outside RESP/REQ respectively. Late responses are dropped.
- Reset mid-operation: next edge goes to IDLE. Any in-flight transaction is abandoned without a write-back.

## Timing
- Reset values:
  - all outputs 0, except ex_ready_o = 1
  - state IDLE
  - counter 0
- Outputs are registered from state and latched fields. mem_req_o falls in the cycle after gnt is sampled.
- Latency from accept edge to wb_valid_o:
  - non-LS or misaligned: 1 cycle
  - store with immediate gnt: 2 cycles
  - load with immediate gnt and rvalid the next cycle: 3 cycles
- Throughput is one instruction per visit to IDLE. ex_ready_o is low in REQ, RESP and WB.
- If gnt and rvalid arrive in the same cycle in REQ, rvalid is ignored; the bus must deliver rvalid at least one cycle after gnt.

## Structure
- Shared defines header (existing ysyx_22040237 defines file) holds:
  - LS info bit indices: LOAD=0, STORE=1, USIGN=2, BYTE=3, DB=4, WORD=5, DW=6
  - LSU state encodings
  - XLEN=64
- One combinational sub-module, ysyx_22040237_lsu_align. Size decode, misalign check, wdata replication, wstrb generation and load extract/extend. Shared by the FSM top.

## Test plan
- ALU pass-through: ls_info=0, alu_res=0x1234, rd=5 → wb_valid 1 cycle later, data 0x1234, wr_en=1, no mem_req.
- Signed byte load: addr=0x8000_0003, rdata=0x0000_0000_8000_0000, lb → data 0xFFFF_FFFF_FFFF_FF80; lbu → 0x80; mem_addr=0x8000_0000.
- Store half: addr=0x...6, rs2=0xABCD → wstrb=0xC0, wdata=0xABCD_ABCD_ABCD_ABCD; gnt delayed 3 cycles → req held, signals stable, wb wr_en=0.
- Misaligned lw at 0x...2 → no mem_req, lsu_misalign_o=1 with wb_valid after 1 cycle, wr_en=0.
- Timeout: gnt never asserted, MEM_TIMEOUT=8 → req drops after 8 cycles, lsu_bus_err_o=1; later rvalid ignored.
- Back-pressure and reset: wb_ready low 4 cycles → outputs stable. rst during RESP → IDLE next edge, all outputs at reset values, following rvalid ignored.
